// File: rtl/uart_pkg.sv
// Shared UART loader types and constants.
// Frame format: 8N1 by default, 8E1 when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int unsigned CLK_DIV_DEFAULT = 434;
  localparam int unsigned DATA_BITS       = 8;
  localparam int unsigned ERR_W           = 8;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: rx synchronizer, frame FSM, mid-bit sampling and optional even-parity check.
// Define UART_PARITY_EN to expect a parity bit between the data bits and the stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 rx,
  output logic                 start_ok,
  output logic                 byte_valid,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 frame_err
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 fall_c;
  logic                 tick_c;
  logic                 stop_ok_c;

  assign fall_c = rx_prev & ~rx_sync;
  assign tick_c = (cnt == '0);

  // Synchronizer plus one history flop for falling-edge detection; idle level is 1.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

`ifdef UART_PARITY_EN
  logic par_err;
  assign stop_ok_c = rx_sync & ~par_err;
`else
  assign stop_ok_c = rx_sync;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      start_ok   <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
      par_err    <= 1'b0;
`endif
    end else begin
      start_ok   <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall_c) begin
            state <= RX_START;
            cnt   <= CNT_W'(CLK_DIV / 2 - 1);
          end
        end
        RX_START: begin
          if (tick_c) begin
            // A line that is high again at mid start bit was a glitch, not a frame.
            if (!rx_sync) begin
              state    <= RX_DATA;
              cnt      <= CNT_W'(CLK_DIV - 1);
              bit_idx  <= '0;
              start_ok <= 1'b1;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (tick_c) begin
            shift   <= {rx_sync, shift[DATA_BITS-1:1]};
            cnt     <= CNT_W'(CLK_DIV - 1);
            bit_idx <= bit_idx + BIT_W'(1);
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
              state <= RX_PARITY;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (tick_c) begin
            par_err <= ^{shift, rx_sync};
            cnt     <= CNT_W'(CLK_DIV - 1);
            state   <= RX_STOP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
`endif
        RX_STOP: begin
          if (tick_c) begin
            if (stop_ok_c) begin
              byte_valid <= 1'b1;
              byte_data  <= shift;
            end else begin
              frame_err <= 1'b1;
            end
            state <= RX_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes into words and writes them to memory, holding the CPU until loaded.
// Define UART_PARITY_EN for 8E1 frames; the default build receives 8N1.
module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned LOAD_WORDS = 24,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          rx,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_BITS*WORD_BYTES-1:0] mem_wdata,
  output logic                          busy,
  output logic                          done,
  output logic                          cpu_hold,
  output logic [ERR_W-1:0]              err_cnt
);

  localparam int unsigned WORD_W = DATA_BITS * WORD_BYTES;
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  logic                 start_ok;
  logic                 byte_valid;
  logic [DATA_BITS-1:0] byte_data;
  logic                 frame_err;

  logic [IDX_W-1:0]     byte_idx;
  logic [ADDR_W-1:0]    word_idx;
  logic [WORD_W-1:0]    word_reg;
  logic [IDX_W-1:0]     slot_c;
  logic [WORD_W-1:0]    word_next_c;

  uart_rx_core #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .rx         (rx),
    .start_ok   (start_ok),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // Byte lane for the incoming byte: MSB-first fill for big endian, LSB-first otherwise.
  always_comb begin
    slot_c      = BIG_ENDIAN ? (IDX_W'(WORD_BYTES - 1) - byte_idx) : byte_idx;
    word_next_c = word_reg;
    for (int unsigned s = 0; s < WORD_BYTES; s++) begin
      if (slot_c == IDX_W'(s)) word_next_c[DATA_BITS*s +: DATA_BITS] = byte_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cpu_hold  <= 1'b1;
      err_cnt   <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      word_reg  <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok && !done) busy <= 1'b1;
      if (frame_err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);

      if (byte_valid && !done) begin
        word_reg <= word_next_c;
        if (byte_idx == IDX_W'(WORD_BYTES - 1)) begin
          byte_idx  <= '0;
          mem_we    <= 1'b1;
          mem_wdata <= word_next_c;
          mem_addr  <= word_idx;
        end else begin
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end

      // Retire the word written last cycle; the final word latches done instead of advancing.
      if (mem_we) begin
        word_reg <= '0;
        if (word_idx == ADDR_W'(LOAD_WORDS - 1)) begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          busy     <= 1'b0;
        end else begin
          word_idx <= word_idx + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: a big-endian and a little-endian instance share one rx line.
// Honours UART_PARITY_EN by sending 8E1 frames and adding a bad-parity scenario.
module tb_uart_prog_loader;

  localparam int unsigned CLK_DIV = 16;
`ifdef UART_PARITY_EN
  localparam int unsigned FRAME_BITS = 11;
`else
  localparam int unsigned FRAME_BITS = 10;
`endif
  // Start edge to mem_we: 3 sync/edge cycles + half bit + (FRAME_BITS-1) bits + 1 byte_valid register.
  localparam int unsigned WE_LAT = 3 + CLK_DIV / 2 + (FRAME_BITS - 1) * CLK_DIV + 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx      = 1'b1;

  logic        be_mem_we, le_mem_we;
  logic [9:0]  be_mem_addr, le_mem_addr;
  logic [31:0] be_mem_wdata, le_mem_wdata;
  logic        be_busy, le_busy, be_done, le_done, be_cpu_hold, le_cpu_hold;
  logic [7:0]  be_err_cnt, le_err_cnt;

  always #5 sys_clk = ~sys_clk;

  uart_prog_loader #(
    .CLK_DIV(CLK_DIV), .WORD_BYTES(4), .ADDR_W(10), .LOAD_WORDS(24), .BIG_ENDIAN(1'b1)
  ) dut_be (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx),
    .mem_we(be_mem_we), .mem_addr(be_mem_addr), .mem_wdata(be_mem_wdata),
    .busy(be_busy), .done(be_done), .cpu_hold(be_cpu_hold), .err_cnt(be_err_cnt)
  );

  uart_prog_loader #(
    .CLK_DIV(CLK_DIV), .WORD_BYTES(4), .ADDR_W(10), .LOAD_WORDS(24), .BIG_ENDIAN(1'b0)
  ) dut_le (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .rx(rx),
    .mem_we(le_mem_we), .mem_addr(le_mem_addr), .mem_wdata(le_mem_wdata),
    .busy(le_busy), .done(le_done), .cpu_hold(le_cpu_hold), .err_cnt(le_err_cnt)
  );

  int unsigned cyc = 0;
  always @(posedge sys_clk) cyc++;

  logic [9:0]  be_addr_q[$];
  logic [31:0] be_data_q[$];
  int unsigned be_cyc_q[$];
  logic [9:0]  le_addr_q[$];
  logic [31:0] le_data_q[$];

  // Write log, sampled mid-cycle.
  always @(negedge sys_clk) begin
    if (be_mem_we) begin
      be_addr_q.push_back(be_mem_addr);
      be_data_q.push_back(be_mem_wdata);
      be_cyc_q.push_back(cyc);
    end
    if (le_mem_we) begin
      le_addr_q.push_back(le_mem_addr);
      le_data_q.push_back(le_mem_wdata);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int be_base  = 0;
  int le_base  = 0;
  int unsigned last_start = 0;

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    rx      = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    be_base = be_addr_q.size();
    le_base = le_addr_q.size();
  endtask

  task automatic idle(input int unsigned n);
    rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    logic [10:0] frame;
`ifdef UART_PARITY_EN
    frame = {stop_bit, par_bit, b, 1'b0};
`else
    frame = {par_bit, stop_bit, b, 1'b0};
`endif
    last_start = cyc;
    for (int i = 0; i < int'(FRAME_BITS); i++) begin
      rx = frame[i];
      repeat (CLK_DIV) @(negedge sys_clk);
    end
    rx = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (be_mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b expected 0", be_mem_we); end
    n_checks++; if (be_mem_addr !== 10'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 000", be_mem_addr); end
    n_checks++; if (be_mem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 00000000", be_mem_wdata); end
    n_checks++; if (be_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", be_busy); end
    n_checks++; if (be_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", be_done); end
    n_checks++; if (be_cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_cpu_hold: got %b expected 1", be_cpu_hold); end
    n_checks++; if (be_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d expected 0", be_err_cnt); end
    n_checks++; if (le_cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_le_cpu_hold: got %b expected 1", le_cpu_hold); end
  endtask

  task automatic test_word_be();
    do_reset();
    idle(2 * CLK_DIV);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h83);
    idle(4);
    n_checks++; if (be_addr_q.size() - be_base !== 1) begin n_fail++; $display("FAIL be_write_count: got %0d expected 1", be_addr_q.size() - be_base); end
    n_checks++; if (be_addr_q[be_base] !== 10'd0) begin n_fail++; $display("FAIL be_addr: got %h expected 000", be_addr_q[be_base]); end
    n_checks++; if (be_data_q[be_base] !== 32'h00002083) begin n_fail++; $display("FAIL be_wdata: got %h expected 00002083", be_data_q[be_base]); end
    n_checks++; if (be_cyc_q[be_base] !== last_start + WE_LAT) begin n_fail++; $display("FAIL be_we_latency: got cycle %0d expected %0d", be_cyc_q[be_base], last_start + WE_LAT); end
    n_checks++; if (le_data_q[le_base] !== 32'h83200000) begin n_fail++; $display("FAIL le_wdata_t1: got %h expected 83200000", le_data_q[le_base]); end
    n_checks++; if (be_busy !== 1'b1 || be_done !== 1'b0 || be_cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL be_status_after_word: got busy=%b done=%b hold=%b expected 1 0 1", be_busy, be_done, be_cpu_hold); end
  endtask

  task automatic test_word_le();
    do_reset();
    idle(2 * CLK_DIV);
    send_byte(8'h00); send_byte(8'h40); send_byte(8'h21); send_byte(8'h03);
    idle(4);
    n_checks++; if (le_addr_q.size() - le_base !== 1) begin n_fail++; $display("FAIL le_write_count: got %0d expected 1", le_addr_q.size() - le_base); end
    n_checks++; if (le_addr_q[le_base] !== 10'd0) begin n_fail++; $display("FAIL le_addr: got %h expected 000", le_addr_q[le_base]); end
    n_checks++; if (le_data_q[le_base] !== 32'h03214000) begin n_fail++; $display("FAIL le_wdata: got %h expected 03214000", le_data_q[le_base]); end
    n_checks++; if (be_data_q[be_base] !== 32'h00402103) begin n_fail++; $display("FAIL be_wdata_t2: got %h expected 00402103", be_data_q[be_base]); end
  endtask

  task automatic test_frame_err();
    do_reset();
    idle(2 * CLK_DIV);
    send_frame(8'h55, 1'b0, ^8'h55);
    idle(2 * CLK_DIV);
    n_checks++; if (be_err_cnt !== 8'd1) begin n_fail++; $display("FAIL ferr_err_cnt: got %0d expected 1", be_err_cnt); end
    n_checks++; if (be_addr_q.size() - be_base !== 0) begin n_fail++; $display("FAIL ferr_no_write: got %0d writes expected 0", be_addr_q.size() - be_base); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(4);
    n_checks++; if (be_addr_q.size() - be_base !== 1) begin n_fail++; $display("FAIL ferr_write_count: got %0d expected 1", be_addr_q.size() - be_base); end
    n_checks++; if (be_data_q[be_base] !== 32'h11223344 || be_addr_q[be_base] !== 10'd0) begin
      n_fail++; $display("FAIL ferr_word: got %h@%h expected 11223344@000", be_data_q[be_base], be_addr_q[be_base]); end
    n_checks++; if (le_data_q[le_base] !== 32'h44332211) begin n_fail++; $display("FAIL ferr_le_word: got %h expected 44332211", le_data_q[le_base]); end
    n_checks++; if (le_err_cnt !== 8'd1) begin n_fail++; $display("FAIL ferr_le_err_cnt: got %0d expected 1", le_err_cnt); end
  endtask

  task automatic test_glitch();
    do_reset();
    idle(CLK_DIV);
    rx = 1'b0;
    repeat (3) @(negedge sys_clk);
    rx = 1'b1;
    repeat (12) @(negedge sys_clk);
    n_checks++; if (be_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_mid: got %b expected 0", be_busy); end
    repeat (40) @(negedge sys_clk);
    n_checks++; if (be_err_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch_err_cnt: got %0d expected 0", be_err_cnt); end
    n_checks++; if (be_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", be_busy); end
    n_checks++; if (be_addr_q.size() - be_base !== 0) begin n_fail++; $display("FAIL glitch_no_write: got %0d writes expected 0", be_addr_q.size() - be_base); end
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    idle(2 * CLK_DIV);
    send_byte(8'hAA);
    rx = 1'b0;
    repeat (CLK_DIV) @(negedge sys_clk);
    rx = 1'b1;
    repeat (2 * CLK_DIV + CLK_DIV / 2) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    n_checks++; if (be_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", be_busy); end
    idle(2 * CLK_DIV);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    idle(4);
    n_checks++; if (be_addr_q.size() - be_base !== 1) begin n_fail++; $display("FAIL midrst_write_count: got %0d expected 1", be_addr_q.size() - be_base); end
    n_checks++; if (be_data_q[be_base] !== 32'h01020304 || be_addr_q[be_base] !== 10'd0) begin
      n_fail++; $display("FAIL midrst_word: got %h@%h expected 01020304@000", be_data_q[be_base], be_addr_q[be_base]); end
    n_checks++; if (le_data_q[le_base] !== 32'h04030201) begin n_fail++; $display("FAIL midrst_le_word: got %h expected 04030201", le_data_q[le_base]); end
    n_checks++; if (be_err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d expected 0", be_err_cnt); end
  endtask

`ifdef UART_PARITY_EN
  task automatic test_parity();
    do_reset();
    idle(2 * CLK_DIV);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(CLK_DIV);
    n_checks++; if (be_err_cnt !== 8'd1) begin n_fail++; $display("FAIL parity_err_cnt: got %0d expected 1", be_err_cnt); end
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    idle(4);
    n_checks++; if (be_addr_q.size() - be_base !== 1) begin n_fail++; $display("FAIL parity_write_count: got %0d expected 1", be_addr_q.size() - be_base); end
    n_checks++; if (be_data_q[be_base] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL parity_word: got %h expected deadbeef", be_data_q[be_base]); end
  endtask
`endif

  task automatic test_load_complete();
    do_reset();
    idle(2 * CLK_DIV);
    for (int i = 0; i < 95; i++) send_byte(8'(i));
    n_checks++; if (be_done !== 1'b0 || be_cpu_hold !== 1'b1) begin
      n_fail++; $display("FAIL load_done_early: got done=%b hold=%b expected 0 1", be_done, be_cpu_hold); end
    send_byte(8'd95);
    idle(4);
    n_checks++; if (be_addr_q.size() - be_base !== 24) begin n_fail++; $display("FAIL load_write_count: got %0d expected 24", be_addr_q.size() - be_base); end
    for (int w = 0; w < 24; w++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4 * w); b1 = 8'(4 * w + 1); b2 = 8'(4 * w + 2); b3 = 8'(4 * w + 3);
      n_checks++; if (be_addr_q[be_base + w] !== 10'(w) || be_data_q[be_base + w] !== {b0, b1, b2, b3}) begin
        n_fail++; $display("FAIL load_word_%0d: got %h@%h expected %h@%h", w, be_data_q[be_base + w], be_addr_q[be_base + w], {b0, b1, b2, b3}, 10'(w)); end
      n_checks++; if (le_data_q[le_base + w] !== {b3, b2, b1, b0}) begin
        n_fail++; $display("FAIL load_le_word_%0d: got %h expected %h", w, le_data_q[le_base + w], {b3, b2, b1, b0}); end
    end
    n_checks++; if (be_done !== 1'b1 || be_cpu_hold !== 1'b0 || be_busy !== 1'b0) begin
      n_fail++; $display("FAIL load_done: got done=%b hold=%b busy=%b expected 1 0 0", be_done, be_cpu_hold, be_busy); end
    n_checks++; if (le_done !== 1'b1 || le_cpu_hold !== 1'b0) begin
      n_fail++; $display("FAIL load_le_done: got done=%b hold=%b expected 1 0", le_done, le_cpu_hold); end
    send_byte(8'hEE);
    idle(CLK_DIV);
    n_checks++; if (be_addr_q.size() - be_base !== 24) begin n_fail++; $display("FAIL load_extra_write: got %0d writes expected 24", be_addr_q.size() - be_base); end
    n_checks++; if (be_mem_addr !== 10'd23 || be_done !== 1'b1 || be_busy !== 1'b0) begin
      n_fail++; $display("FAIL load_after_done: got addr=%h done=%b busy=%b expected 017 1 0", be_mem_addr, be_done, be_busy); end
  endtask

  initial begin
    test_reset();
    test_word_be();
    test_word_le();
    test_frame_err();
    test_glitch();
    test_reset_mid_byte();
`ifdef UART_PARITY_EN
    test_parity();
`endif
    test_load_complete();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
